// File: rtl/fetch_queue_unit.sv
// Fetch queue unit: issues sequential instruction fetches over a valid/ready
// request channel, collects in-order responses in a DEPTH-entry queue and
// presents {instr, pc, pc+INSTR_BYTES} to decode. A redirect flushes the queue
// and arranges for every stale in-flight response to be silently dropped.
module fetch_queue_unit #(
   parameter int                    DATA_WIDTH      = 32,
   parameter int                    ADDR_WIDTH      = 32,
   parameter int                    DEPTH           = 4,
   parameter int                    MAX_OUTSTANDING = 2,
   parameter int                    INSTR_BYTES     = 4,
   parameter logic [ADDR_WIDTH-1:0] RESET_ADDR      = '0
) (
   input  logic                      clk,
   input  logic                      reset,
   output logic                      imem_req_valid,
   input  logic                      imem_req_ready,
   output logic [ADDR_WIDTH-1:0]     imem_req_addr,
   input  logic                      imem_resp_valid,
   input  logic [DATA_WIDTH-1:0]     imem_resp_data,
   input  logic                      redirect,
   input  logic [ADDR_WIDTH-1:0]     redirect_target,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_WIDTH-1:0]     out_instr,
   output logic [ADDR_WIDTH-1:0]     out_pc,
   output logic [ADDR_WIDTH-1:0]     out_pc_plus_4,
   output logic [$clog2(DEPTH):0]    queue_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [ADDR_WIDTH-1:0] INC        = ADDR_WIDTH'(INSTR_BYTES);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(INSTR_BYTES - 1));

   // Redirect targets are forced onto an instruction boundary.
   function automatic logic [ADDR_WIDTH-1:0] align_pc(input logic [ADDR_WIDTH-1:0] a);
      return a & ALIGN_MASK;
   endfunction

   logic [ADDR_WIDTH-1:0] r_fetch_pc;
   logic [ADDR_WIDTH-1:0] r_resp_pc;
   logic [DATA_WIDTH-1:0] r_q_instr [DEPTH];
   logic [ADDR_WIDTH-1:0] r_q_pc    [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic [CNT_W-1:0]      r_inflight;
   logic [CNT_W-1:0]      r_drop_cnt;

   logic [CNT_W:0]        w_occupied;
   logic                  w_credit_ok;
   logic                  w_req_fire;
   logic                  w_resp_ok;
   logic                  w_push;
   logic                  w_out_valid;
   logic                  w_pop;

   // Queue slots plus in-flight requests never exceed DEPTH, so every
   // accepted request already owns a queue slot for its response.
   assign w_occupied  = {1'b0, r_count} + {1'b0, r_inflight};
   assign w_credit_ok = (r_inflight < CNT_W'(MAX_OUTSTANDING)) &&
                        (w_occupied < (CNT_W+1)'(DEPTH));

   assign imem_req_valid = reset && !redirect && w_credit_ok;
   assign imem_req_addr  = r_fetch_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response with nothing in flight is a protocol error and is ignored.
   assign w_resp_ok = imem_resp_valid && (r_inflight != '0);
   assign w_push    = w_resp_ok && (r_drop_cnt == '0);

   assign w_out_valid   = reset && !redirect && (r_count != '0);
   assign w_pop         = w_out_valid && out_ready;
   assign out_valid     = w_out_valid;
   assign out_instr     = w_out_valid ? r_q_instr[r_rd_ptr] : '0;
   assign out_pc        = w_out_valid ? r_q_pc[r_rd_ptr] : '0;
   assign out_pc_plus_4 = w_out_valid ? (r_q_pc[r_rd_ptr] + INC) : '0;
   assign queue_count   = reset ? r_count : '0;

   // Control state: PCs, queue pointers, credit and stale-drop counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fetch_pc <= RESET_ADDR;
         r_resp_pc  <= RESET_ADDR;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop_cnt <= '0;
      end else if (redirect) begin
         // No request fires this cycle; a response arriving now is itself
         // discarded, so only the remaining in-flight ones must be dropped.
         r_fetch_pc <= align_pc(redirect_target);
         r_resp_pc  <= align_pc(redirect_target);
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_inflight <= r_inflight - CNT_W'(w_resp_ok);
         r_drop_cnt <= r_inflight - CNT_W'(w_resp_ok);
      end else begin
         if (w_req_fire) begin
            r_fetch_pc <= r_fetch_pc + INC;
         end
         r_inflight <= r_inflight + CNT_W'(w_req_fire) - CNT_W'(w_resp_ok);
         if (w_resp_ok && (r_drop_cnt != '0)) begin
            r_drop_cnt <= r_drop_cnt - CNT_W'(1);
         end
         if (w_push) begin
            r_wr_ptr  <= r_wr_ptr + PTR_W'(1);
            r_resp_pc <= r_resp_pc + INC;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Queue storage: data only, validity is tracked by the control state.
   always_ff @(posedge clk) begin
      if (reset && !redirect && w_push) begin
         r_q_instr[r_wr_ptr] <= imem_resp_data;
         r_q_pc[r_wr_ptr]    <= r_resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: a memory model that echoes the address as data,
// directed phases that queue the expected decode-side pc sequence, and a
// monitor that pops and compares each accepted output.
module tb_fetch_queue_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data  = '0;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [31:0] out_pc_plus_4;
   logic [2:0]  queue_count;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [31:0] exp_q  [$];
   logic [31:0] pend_q [$];
   logic        mem_hold = 1'b1;
   logic        inj_resp = 1'b0;
   logic [31:0] inj_data = '0;
   int          cyc;

   fetch_queue_unit dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect        (redirect),
      .redirect_target (redirect_target),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .out_pc_plus_4   (out_pc_plus_4),
      .queue_count     (queue_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      reset     = 1'b0;
      redirect  = 1'b0;
      out_ready = 1'b0;
      mem_hold  = 1'b1;
      inj_resp  = 1'b0;
      repeat (n) tick();
      pend_q.delete();
      exp_q.delete();
      reset = 1'b1;
   endtask

   task automatic wait_drain(input int limit, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (exp_q.size() != 0 && cycles < limit);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
         exp_q.delete();
      end
      out_ready = 1'b0;
   endtask

   // Memory model: one-cycle latency, in order, data = address.
   initial begin
      forever begin
         @(negedge clk);
         if (inj_resp) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inj_data;
         end else if (!mem_hold && pend_q.size() != 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = pend_q.pop_front();
         end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
         end
         if (imem_req_valid && imem_req_ready) pend_q.push_back(imem_req_addr);
      end
   end

   // Monitor: every accepted output must match the next expected pc.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_output: got pc %h, expected none", out_pc);
            end else begin
               e = exp_q.pop_front();
               check("out_pc", out_pc, e);
               check("out_instr", out_instr, e);
               check("out_pc_plus_4", out_pc_plus_4, e + 32'd4);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      reset           = 1'b0;
      imem_req_ready  = 1'b1;
      redirect        = 1'b0;
      redirect_target = '0;
      out_ready       = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count", 32'(queue_count), 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_instr", out_instr, 32'd0);
      check("rst_out_pc4", out_pc_plus_4, 32'd0);

      // Streaming
      do_reset(1);
      mem_hold  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
      #1;
      check("stream_first_valid", 32'(imem_req_valid), 32'd1);
      check("stream_first_addr", imem_req_addr, 32'h0);
      wait_drain(40, cyc);
      check("stream_cycles", 32'(cyc), 32'd10);

      // Stall until full, then release
      do_reset(2);
      mem_hold = 1'b0;
      repeat (10) tick();
      check("full_count", 32'(queue_count), 32'd4);
      check("full_req_valid", 32'(imem_req_valid), 32'd0);
      check("full_out_valid", 32'(out_valid), 32'd1);
      check("full_out_pc", out_pc, 32'h0);
      check("full_out_instr", out_instr, 32'h0);
      check("full_out_pc4", out_pc_plus_4, 32'h4);
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      out_ready = 1'b1;
      tick();
      check("resume_req_valid", 32'(imem_req_valid), 32'd1);
      check("resume_req_addr", imem_req_addr, 32'h10);
      wait_drain(40, cyc);

      // Redirect with two fetches in flight (0x20, 0x24)
      do_reset(2);
      redirect        = 1'b1;
      redirect_target = 32'h20;
      #1;
      check("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
      redirect = 1'b0;
      #1;
      check("redir20_req_addr", imem_req_addr, 32'h20);
      check("redir20_req_valid", 32'(imem_req_valid), 32'd1);
      tick();
      tick();
      check("max_outstanding_block", 32'(imem_req_valid), 32'd0);
      redirect        = 1'b1;
      redirect_target = 32'h100;
      tick();
      redirect  = 1'b0;
      mem_hold  = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(32'h100);
      exp_q.push_back(32'h104);
      exp_q.push_back(32'h108);
      #1;
      check("drain_credit_block", 32'(imem_req_valid), 32'd0);
      tick();
      check("redir100_req_valid", 32'(imem_req_valid), 32'd1);
      check("redir100_req_addr", imem_req_addr, 32'h100);
      wait_drain(40, cyc);

      // Redirect coincident with a response, queue holding 2, out_ready=1
      do_reset(2);
      tick();
      tick();
      mem_hold = 1'b0;
      tick();
      tick();
      mem_hold = 1'b1;
      tick();
      check("coinc_pre_count", 32'(queue_count), 32'd2);
      mem_hold        = 1'b0;
      redirect        = 1'b1;
      redirect_target = 32'h200;
      out_ready       = 1'b1;
      exp_q.push_back(32'h200);
      exp_q.push_back(32'h204);
      exp_q.push_back(32'h208);
      #1;
      check("coinc_out_valid", 32'(out_valid), 32'd0);
      check("coinc_out_pc", out_pc, 32'h0);
      tick();
      redirect = 1'b0;
      #1;
      check("coinc_post_count", 32'(queue_count), 32'd0);
      check("coinc_req_valid", 32'(imem_req_valid), 32'd1);
      check("coinc_req_addr", imem_req_addr, 32'h200);
      wait_drain(40, cyc);

      // Misaligned target and address wrap
      repeat (3) tick();
      redirect        = 1'b1;
      redirect_target = 32'hFFFF_FFFE;
      tick();
      redirect  = 1'b0;
      out_ready = 1'b1;
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0000_0000);
      exp_q.push_back(32'h0000_0004);
      #1;
      check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      wait_drain(40, cyc);

      // Reset mid-stream, then a stray response with nothing in flight
      do_reset(2);
      tick();
      tick();
      mem_hold = 1'b0;
      tick();
      tick();
      mem_hold = 1'b1;
      tick();
      check("midrst_pre_count", 32'(queue_count), 32'd2);
      reset = 1'b0;
      #1;
      check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_count", 32'(queue_count), 32'd0);
      check("midrst_out_pc", out_pc, 32'd0);
      check("midrst_out_instr", out_instr, 32'd0);
      check("midrst_out_pc4", out_pc_plus_4, 32'd0);
      tick();
      reset = 1'b1;
      pend_q.delete();
      mem_hold  = 1'b0;
      inj_resp  = 1'b1;
      inj_data  = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      #1;
      check("postrst_req_valid", 32'(imem_req_valid), 32'd1);
      check("postrst_req_addr", imem_req_addr, 32'h0);
      tick();
      inj_resp = 1'b0;
      check("stray_resp_ignored", 32'(queue_count), 32'd0);
      wait_drain(40, cyc);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
